adder_psum_scheduler: RTL and testbench
=======================================

Name: adder_psum_scheduler

Overview:
- Clocked scheduler that sequences the partial-sum adder of one SNN adder node.
- Collects the three per-lane partial sums of each output neuron from the NoC decoder side and detects when a neuron has all three lanes.
- For each complete neuron: fetches the membrane potential from memory, issues one sum, thresholds it, emits a result packet and writes back the new potential.

Parameters:
PSUM_W, 9, partial-sum width (unsigned)
POT_W, 10, membrane-potential width (unsigned)
NEURON_N, 25, output neurons handled by this adder
IDX_W, 5, neuron index width (clog2 of NEURON_N)
THRESH, 64, firing threshold; spike when sum >= THRESH
CQ_DEPTH, 4, completion-queue depth (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
psum_valid  in  1  partial-sum offer
psum_ready  out  1  partial-sum accept
psum_lane  in  2  lane 0..2; value 3 is illegal
psum_idx  in  IDX_W  target neuron
psum_data  in  PSUM_W  partial sum
mem_rd_req  out  1  potential read strobe, one cycle
mem_rd_idx  out  IDX_W  read address
mem_rd_valid  in  1  read data valid
mem_rd_data  in  POT_W  stored potential
mem_wr_en  out  1  write-back strobe, one cycle
mem_wr_idx  out  IDX_W  write address
mem_wr_data  out  POT_W  new potential
out_valid  out  1  result offer
out_ready  in  1  result accept
out_idx  out  IDX_W  neuron index
out_sum  out  POT_W  saturated sum
out_spike  out  1  sum >= THRESH
busy  out  1  FSM not IDLE or queue non-empty

Behaviour:
- Reset (async, rst_n=0): all scoreboard valid bits cleared; queue empty; FSM to IDLE; mem_rd_req, mem_wr_en and out_valid are 0; out_idx, out_sum, out_spike, mem_*_idx and mem_wr_data are 0; busy is 0. Reset mid-operation drops all in-flight work; no write-back is issued.
- Scoreboard: per neuron, 3 valid bits plus 3 PSUM_W registers.
- Accept on psum_valid & psum_ready: store data, set the lane bit.
- psum_ready=0 when any of these holds:
  - the target lane bit is already set (duplicate stalls until the neuron drains);
  - psum_lane==3;
  - the accept would complete the neuron while the queue is full.
- Completion: an accept that sets the last missing bit pushes psum_idx into the queue at the same edge. A neuron is pushed exactly once.
- FSM states and transitions:
  - IDLE: go to RD_REQ when the queue is non-empty; head index latched.
  - RD_REQ: mem_rd_req=1 and mem_rd_idx=head for one cycle; then RD_WAIT.
  - RD_WAIT: wait for mem_rd_valid (ignored in all other states); latch data; then SUM.
  - SUM: compute and register the result (see arithmetic); then OUT.
  - OUT: out_valid=1 with outputs held stable until out_ready. On handshake, in the same cycle:
    - pulse mem_wr_en with mem_wr_idx=head and mem_wr_data = out_spike ? 0 : out_sum;
    - pop the queue;
    - clear the 3 bits of head;
    - next state IDLE.
- Arithmetic: sum = pot + p0 + p1 + p2, computed at POT_W+2 bits, then saturated to 2^POT_W-1. out_spike = (saturated sum >= THRESH).
- Latency:
  - Third-lane accept at edge t, queue non-empty after t.
  - mem_rd_req high in cycle t+2.
  - If mem_rd_valid arrives in cycle c, out_valid rises in cycle c+2.
- Simultaneous events:
  - A push in the same cycle as a pop is allowed, and is allowed when the queue is full.
  - An offer to a lane being cleared in the OUT handshake cycle sees ready=0; it is accepted from the next cycle.
- Other neurons keep accepting partial sums while the FSM is busy.

Decomposition:
- Shared package adder_sched_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, SUM, OUT);
  - LANES=3;
  - the sat_add function (width-parameterised saturating add).
- Sub-module: adder_sched_cq, a synchronous FIFO of neuron indices with full/empty flags, depth CQ_DEPTH, same reset.

Test Plan:
- idx 7 gets lanes 0,1,2 with data 10,20,30; mem returns 5 one cycle after req → out_idx=7, out_sum=65, out_spike=1, mem_wr_data=0; mem_rd_req exactly 2 cycles after the third accept.
- idx 3 gets 1,2,3 and mem returns 4 → out_sum=10, spike=0, mem_wr_data=10.
- Saturation: lanes 511,511,511 and pot 1000 → out_sum=1023, spike=1.
- Duplicate: idx 2 lane 1 offered twice → second offer ready=0 until idx 2's OUT handshake, accepted the next cycle; out_ready held low 5 cycles → outputs stable and a single mem_wr_en.
- Queue full: complete 4 neurons with out_ready=0, then a completing offer for a 5th → ready=0; a non-completing offer for another neuron → accepted; after one pop the 5th is accepted; outputs emerge in completion order.
- rst_n low during RD_WAIT → outputs zero immediately; no mem_wr_en; a fresh complete neuron after reset is processed normally.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the SNN adder-node partial-sum scheduler.
package adder_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        SUM     = 3'd3,
        OUT     = 3'd4
    } state_t;

    localparam int LANES = 3;

    // Saturating add clamped to 2^w-1; operands must stay below 2^31.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [31:0] sum_s;
        logic [31:0] max_s;
        sum_s = a + b;
        max_s = (32'd1 << w) - 32'd1;
        if (sum_s > max_s) begin
            sat_add = max_s;
        end else begin
            sat_add = sum_s;
        end
    endfunction

endpackage

// File: rtl/adder_sched_cq.sv
// Completion queue: synchronous FIFO of neuron indices awaiting the adder.
module adder_sched_cq
    import adder_sched_pkg::*;
#(
    parameter int IDX_W = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             pop,
    output logic [IDX_W-1:0] head_idx,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [IDX_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   cnt_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign full     = (cnt_r == (PTR_W+1)'(DEPTH));
    assign empty    = (cnt_r == {(PTR_W+1){1'b0}});
    // A full queue still takes a push when the head leaves in the same cycle.
    assign wr_ok_s  = push & (~full | pop);
    assign rd_ok_s  = pop & ~empty;
    assign head_idx = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {IDX_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {(PTR_W+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                mem_r[wr_ptr_r] <= push_idx;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   cnt_r <= cnt_r + (PTR_W+1)'(1);
                2'b01:   cnt_r <= cnt_r - (PTR_W+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/adder_psum_scheduler.sv
// Collects three partial-sum lanes per output neuron and sequences the
// fetch / add / threshold / write-back of each completed neuron.
module adder_psum_scheduler
    import adder_sched_pkg::*;
#(
    parameter int PSUM_W   = 9,
    parameter int POT_W    = 10,
    parameter int NEURON_N = 25,
    parameter int IDX_W    = 5,
    parameter int THRESH   = 64,
    parameter int CQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [1:0]        psum_lane,
    input  logic [IDX_W-1:0]  psum_idx,
    input  logic [PSUM_W-1:0] psum_data,
    output logic              mem_rd_req,
    output logic [IDX_W-1:0]  mem_rd_idx,
    input  logic              mem_rd_valid,
    input  logic [POT_W-1:0]  mem_rd_data,
    output logic              mem_wr_en,
    output logic [IDX_W-1:0]  mem_wr_idx,
    output logic [POT_W-1:0]  mem_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [POT_W-1:0]  out_sum,
    output logic              out_spike,
    output logic              busy
);

    logic [LANES-1:0]  vld_r  [NEURON_N];
    logic [PSUM_W-1:0] data_r [NEURON_N][LANES];

    state_t            state_r;
    state_t            state_next_s;
    logic [IDX_W-1:0]  head_r;
    logic [IDX_W-1:0]  out_idx_r;
    logic [POT_W-1:0]  pot_r;
    logic [POT_W-1:0]  out_sum_r;
    logic [POT_W-1:0]  wr_data_r;
    logic              out_spike_r;
    logic              out_valid_r;
    logic              rd_req_r;

    logic [LANES-1:0]  lane_oh_s;
    logic [LANES-1:0]  cur_vld_s;
    logic              idx_ok_s;
    logic              ready_s;
    logic              accept_s;
    logic              push_s;
    logic              hs_s;
    logic              cq_full_s;
    logic              cq_empty_s;
    logic [IDX_W-1:0]  cq_head_s;
    logic [POT_W+1:0]  psum_tot_s;
    logic [POT_W-1:0]  sat_s;
    logic              spike_s;

    adder_sched_cq #(
        .IDX_W (IDX_W),
        .DEPTH (CQ_DEPTH)
    ) u_cq (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .push_idx (psum_idx),
        .pop      (hs_s),
        .head_idx (cq_head_s),
        .full     (cq_full_s),
        .empty    (cq_empty_s)
    );

    // Offer qualification: lane decode, duplicate and queue-full stalls.
    always_comb begin
        lane_oh_s = 3'b000;
        cur_vld_s = 3'b000;
        case (psum_lane)
            2'd0:    lane_oh_s = 3'b001;
            2'd1:    lane_oh_s = 3'b010;
            2'd2:    lane_oh_s = 3'b100;
            default: lane_oh_s = 3'b000;
        endcase
        idx_ok_s = (psum_idx < IDX_W'(NEURON_N));
        if (idx_ok_s) begin
            cur_vld_s = vld_r[psum_idx];
        end else begin
            cur_vld_s = 3'b000;
        end
        ready_s  = idx_ok_s & (lane_oh_s != 3'b000) & ((cur_vld_s & lane_oh_s) == 3'b000)
                 & ~(((cur_vld_s | lane_oh_s) == 3'b111) & cq_full_s);
        accept_s = psum_valid & ready_s;
        push_s   = accept_s & ((cur_vld_s | lane_oh_s) == 3'b111);
    end

    // Head bits still read as set during the handshake cycle, so a re-offer waits one more cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NEURON_N; n++) begin
                vld_r[n] <= {LANES{1'b0}};
                for (int l = 0; l < LANES; l++) begin
                    data_r[n][l] <= {PSUM_W{1'b0}};
                end
            end
        end else begin
            if (hs_s) begin
                vld_r[head_r] <= {LANES{1'b0}};
            end
            if (accept_s) begin
                vld_r[psum_idx][psum_lane]  <= 1'b1;
                data_r[psum_idx][psum_lane] <= psum_data;
            end
        end
    end

    // Potential plus the three lanes of the head neuron, saturated.
    always_comb begin
        psum_tot_s = (POT_W+2)'(data_r[head_r][2'd0]) + (POT_W+2)'(data_r[head_r][2'd1])
                   + (POT_W+2)'(data_r[head_r][2'd2]);
        sat_s      = POT_W'(sat_add(32'(pot_r), 32'(psum_tot_s), POT_W));
        spike_s    = (sat_s >= POT_W'(THRESH));
    end

    assign hs_s = out_valid_r & out_ready;

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!cq_empty_s) begin
                    state_next_s = RD_REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_REQ:  state_next_s = RD_WAIT;
            RD_WAIT: begin
                if (mem_rd_valid) begin
                    state_next_s = SUM;
                end else begin
                    state_next_s = RD_WAIT;
                end
            end
            SUM:     state_next_s = OUT;
            OUT: begin
                if (hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register plus registered strobes and result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rd_req_r    <= 1'b0;
            out_valid_r <= 1'b0;
            head_r      <= {IDX_W{1'b0}};
            pot_r       <= {POT_W{1'b0}};
            out_idx_r   <= {IDX_W{1'b0}};
            out_sum_r   <= {POT_W{1'b0}};
            out_spike_r <= 1'b0;
            wr_data_r   <= {POT_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            rd_req_r    <= (state_next_s == RD_REQ);
            out_valid_r <= (state_next_s == OUT);
            if ((state_r == IDLE) && !cq_empty_s) begin
                head_r <= cq_head_s;
            end
            if ((state_r == RD_WAIT) && mem_rd_valid) begin
                pot_r <= mem_rd_data;
            end
            if (state_r == SUM) begin
                out_idx_r   <= head_r;
                out_sum_r   <= sat_s;
                out_spike_r <= spike_s;
                wr_data_r   <= spike_s ? {POT_W{1'b0}} : sat_s;
            end
        end
    end

    assign psum_ready  = ready_s;
    assign mem_rd_req  = rd_req_r;
    assign mem_rd_idx  = head_r;
    assign mem_wr_en   = hs_s;
    assign mem_wr_idx  = head_r;
    assign mem_wr_data = wr_data_r;
    assign out_valid   = out_valid_r;
    assign out_idx     = out_idx_r;
    assign out_sum     = out_sum_r;
    assign out_spike   = out_spike_r;
    assign busy        = (state_r != IDLE) | ~cq_empty_s;

endmodule

// File: tb/tb_adder_psum_scheduler.sv
// Directed bench for adder_psum_scheduler with a one-cycle-latency potential memory model.
module tb_adder_psum_scheduler;

    logic       clk;
    logic       rst_n;
    logic       psum_valid;
    logic       psum_ready;
    logic [1:0] psum_lane;
    logic [4:0] psum_idx;
    logic [8:0] psum_data;
    logic       mem_rd_req;
    logic [4:0] mem_rd_idx;
    logic       mem_rd_valid;
    logic [9:0] mem_rd_data;
    logic       mem_wr_en;
    logic [4:0] mem_wr_idx;
    logic [9:0] mem_wr_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_idx;
    logic [9:0] out_sum;
    logic       out_spike;
    logic       busy;

    int         n_cmp;
    int         n_err;
    logic [9:0] pot_mem [32];
    logic       mem_hold;
    logic       pend;
    logic [4:0] pend_idx;
    int         wr_cnt;

    adder_psum_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .psum_valid   (psum_valid),
        .psum_ready   (psum_ready),
        .psum_lane    (psum_lane),
        .psum_idx     (psum_idx),
        .psum_data    (psum_data),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_idx   (mem_rd_idx),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_idx   (mem_wr_idx),
        .mem_wr_data  (mem_wr_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_sum      (out_sum),
        .out_spike    (out_spike),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model: answers a read request one cycle later, counts write strobes.
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = 10'd0;
        pend         = 1'b0;
        pend_idx     = 5'd0;
        wr_cnt       = 0;
        forever begin
            @(negedge clk);
            if (mem_rd_req === 1'b1 && !mem_hold) begin
                pend     = 1'b1;
                pend_idx = mem_rd_idx;
            end
            if (mem_wr_en === 1'b1) wr_cnt++;
            @(posedge clk);
            #1;
            if (pend) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = pot_mem[pend_idx];
                pend         = 1'b0;
            end else begin
                mem_rd_valid = 1'b0;
            end
        end
    end

    task automatic send_psum(input logic [4:0] idx, input logic [1:0] lane,
                             input logic [8:0] data, output int waited);
        waited     = -1;
        psum_valid = 1'b1;
        psum_idx   = idx;
        psum_lane  = lane;
        psum_data  = data;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (psum_ready === 1'b1) begin
                waited = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
    endtask

    task automatic collect(output logic [4:0] idx, output logic [9:0] sum, output logic spk,
                           output logic wen, output logic [4:0] widx, output logic [9:0] wdata,
                           output int cyc);
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
        idx   = out_idx;
        sum   = out_sum;
        spk   = out_spike;
        wen   = mem_wr_en;
        widx  = mem_wr_idx;
        wdata = mem_wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_cmp++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL rst_rd_req: got %0b want 0", mem_rd_req); end
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %0b want 0", mem_wr_en); end
        n_cmp++; if ({out_idx, out_sum, out_spike, mem_wr_data, mem_rd_idx, mem_wr_idx} !== 36'd0) begin
            n_err++; $display("FAIL rst_fields: got %0h want 0", {out_idx, out_sum, out_spike, mem_wr_data, mem_rd_idx, mem_wr_idx}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        psum_idx  = 5'd0;
        psum_lane = 2'd0;
        #1;
        n_cmp++; if (psum_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_lane0: got %0b want 1", psum_ready); end
        psum_lane = 2'd3;
        #1;
        n_cmp++; if (psum_ready !== 1'b0) begin n_err++; $display("FAIL ready_lane3: got %0b want 0", psum_ready); end
        psum_lane = 2'd0;
    endtask

    task automatic test_spike_latency();
        logic [4:0] idx, widx; logic [9:0] sum, wdata; logic spk, wen; int w, cyc;
        pot_mem[7] = 10'd5;
        out_ready  = 1'b1;
        send_psum(5'd7, 2'd0, 9'd10, w);
        send_psum(5'd7, 2'd1, 9'd20, w);
        send_psum(5'd7, 2'd2, 9'd30, w);
        n_cmp++; if (w !== 0) begin n_err++; $display("FAIL t1_accept_wait: got %0d want 0", w); end
        @(negedge clk);
        n_cmp++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL t1_req_early: got %0b want 0", mem_rd_req); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %0b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (mem_rd_req !== 1'b1) begin n_err++; $display("FAIL t1_req_t2: got %0b want 1", mem_rd_req); end
        n_cmp++; if (mem_rd_idx !== 5'd7) begin n_err++; $display("FAIL t1_rd_idx: got %0d want 7", mem_rd_idx); end
        collect(idx, sum, spk, wen, widx, wdata, cyc);
        n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL t1_out_latency: got %0d want 3", cyc); end
        n_cmp++; if (idx !== 5'd7) begin n_err++; $display("FAIL t1_idx: got %0d want 7", idx); end
        n_cmp++; if (sum !== 10'd65) begin n_err++; $display("FAIL t1_sum: got %0d want 65", sum); end
        n_cmp++; if (spk !== 1'b1) begin n_err++; $display("FAIL t1_spike: got %0b want 1", spk); end
        n_cmp++; if (wen !== 1'b1 || widx !== 5'd7 || wdata !== 10'd0) begin
            n_err++; $display("FAIL t1_writeback: got en=%0b idx=%0d data=%0d want 1/7/0", wen, widx, wdata); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_arith();
        logic [4:0] idx, widx; logic [9:0] sum, wdata; logic spk, wen; int w, cyc;
        logic [4:0] t_idx  [4] = '{5'd3, 5'd24, 5'd0, 5'd1};
        logic [8:0] t_p    [4] = '{9'd1, 9'd511, 9'd20, 9'd20};
        logic [9:0] t_pot  [4] = '{10'd4, 10'd1000, 10'd4, 10'd3};
        logic [9:0] t_sum  [4] = '{10'd10, 10'd1023, 10'd64, 10'd63};
        logic       t_spk  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [9:0] t_wd   [4] = '{10'd10, 10'd0, 10'd0, 10'd63};
        logic [8:0] p1, p2;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pot_mem[t_idx[k]] = t_pot[k];
            p1 = (k == 0) ? 9'd2 : t_p[k];
            p2 = (k == 0) ? 9'd3 : t_p[k];
            send_psum(t_idx[k], 2'd2, p2, w);
            send_psum(t_idx[k], 2'd0, t_p[k], w);
            send_psum(t_idx[k], 2'd1, p1, w);
            collect(idx, sum, spk, wen, widx, wdata, cyc);
            n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL arith%0d_timeout: got %0d want >0", k, cyc); end
            n_cmp++; if (idx !== t_idx[k]) begin n_err++; $display("FAIL arith%0d_idx: got %0d want %0d", k, idx, t_idx[k]); end
            n_cmp++; if (sum !== t_sum[k]) begin n_err++; $display("FAIL arith%0d_sum: got %0d want %0d", k, sum, t_sum[k]); end
            n_cmp++; if (spk !== t_spk[k]) begin n_err++; $display("FAIL arith%0d_spike: got %0b want %0b", k, spk, t_spk[k]); end
            n_cmp++; if (wen !== 1'b1 || wdata !== t_wd[k]) begin
                n_err++; $display("FAIL arith%0d_wb: got en=%0b data=%0d want 1/%0d", k, wen, wdata, t_wd[k]); end
        end
    endtask

    task automatic test_duplicate();
        logic [4:0] idx, widx; logic [9:0] sum, wdata; logic spk, wen; int w, cyc, wr0, seen;
        pot_mem[2] = 10'd7;
        out_ready  = 1'b0;
        send_psum(5'd2, 2'd0, 9'd1, w);
        send_psum(5'd2, 2'd1, 9'd2, w);
        send_psum(5'd2, 2'd2, 9'd3, w);
        wr0 = wr_cnt;
        psum_valid = 1'b1; psum_idx = 5'd2; psum_lane = 2'd1; psum_data = 9'd9;
        @(negedge clk);
        n_cmp++; if (psum_ready !== 1'b0) begin n_err++; $display("FAIL dup_ready: got %0b want 0", psum_ready); end
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            if (out_valid === 1'b1) seen = 1; else @(negedge clk);
        end
        n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL dup_out_timeout: got %0d want 1", seen); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_idx !== 5'd2 || out_sum !== 10'd13 || out_spike !== 1'b0) begin
                n_err++; $display("FAIL dup_hold%0d: got v=%0b idx=%0d sum=%0d want 1/2/13", i, out_valid, out_idx, out_sum); end
            n_cmp++; if (mem_wr_en !== 1'b0 || psum_ready !== 1'b0) begin
                n_err++; $display("FAIL dup_hold_strobe%0d: got wr=%0b rdy=%0b want 0/0", i, mem_wr_en, psum_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_wr_en !== 1'b1 || mem_wr_idx !== 5'd2 || mem_wr_data !== 10'd13) begin
            n_err++; $display("FAIL dup_hs_wb: got en=%0b idx=%0d data=%0d want 1/2/13", mem_wr_en, mem_wr_idx, mem_wr_data); end
        n_cmp++; if (psum_ready !== 1'b0) begin n_err++; $display("FAIL dup_hs_ready: got %0b want 0", psum_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (psum_ready !== 1'b1) begin n_err++; $display("FAIL dup_after_ready: got %0b want 1", psum_ready); end
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (wr_cnt - wr0 !== 1) begin n_err++; $display("FAIL dup_wr_count: got %0d want 1", wr_cnt - wr0); end
        pot_mem[2] = 10'd0;
        send_psum(5'd2, 2'd0, 9'd0, w);
        send_psum(5'd2, 2'd2, 9'd0, w);
        collect(idx, sum, spk, wen, widx, wdata, cyc);
        n_cmp++; if (idx !== 5'd2 || sum !== 10'd9 || wdata !== 10'd9) begin
            n_err++; $display("FAIL dup_drain: got idx=%0d sum=%0d wdata=%0d want 2/9/9", idx, sum, wdata); end
    endtask

    task automatic test_queue_full();
        logic [4:0] idx, widx; logic [9:0] sum, wdata; logic spk, wen; int w, cyc;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) pot_mem[10 + k] = 10'(100 + 10 * k);
        send_psum(5'd14, 2'd0, 9'd1, w);
        send_psum(5'd14, 2'd1, 9'd2, w);
        for (int k = 0; k < 4; k++) begin
            send_psum(5'(10 + k), 2'd0, 9'd1, w);
            send_psum(5'(10 + k), 2'd1, 9'd2, w);
            send_psum(5'(10 + k), 2'd2, 9'd3, w);
        end
        psum_valid = 1'b1; psum_idx = 5'd14; psum_lane = 2'd2; psum_data = 9'd3;
        @(negedge clk);
        n_cmp++; if (psum_ready !== 1'b0) begin n_err++; $display("FAIL qf_complete_ready: got %0b want 0", psum_ready); end
        @(posedge clk);
        #1;
        psum_idx = 5'd15; psum_lane = 2'd0; psum_data = 9'd1;
        @(negedge clk);
        n_cmp++; if (psum_ready !== 1'b1) begin n_err++; $display("FAIL qf_partial_ready: got %0b want 1", psum_ready); end
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
        out_ready  = 1'b1;
        collect(idx, sum, spk, wen, widx, wdata, cyc);
        n_cmp++; if (idx !== 5'd10 || sum !== 10'd106) begin
            n_err++; $display("FAIL qf_first: got idx=%0d sum=%0d want 10/106", idx, sum); end
        send_psum(5'd14, 2'd2, 9'd3, w);
        n_cmp++; if (w !== 0) begin n_err++; $display("FAIL qf_after_pop_wait: got %0d want 0", w); end
        for (int k = 1; k < 5; k++) begin
            collect(idx, sum, spk, wen, widx, wdata, cyc);
            n_cmp++; if (idx !== 5'(10 + k) || sum !== 10'(106 + 10 * k)) begin
                n_err++; $display("FAIL qf_order%0d: got idx=%0d sum=%0d want %0d/%0d", k, idx, sum, 10 + k, 106 + 10 * k); end
        end
    endtask

    task automatic test_reset_midop();
        logic [4:0] idx, widx; logic [9:0] sum, wdata; logic spk, wen; int w, cyc, wr0, seen;
        mem_hold   = 1'b1;
        pot_mem[5] = 10'd1;
        send_psum(5'd5, 2'd0, 9'd100, w);
        send_psum(5'd5, 2'd1, 9'd100, w);
        send_psum(5'd5, 2'd2, 9'd100, w);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (mem_rd_req === 1'b1) seen = 1;
        end
        n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL rm_req_timeout: got %0d want 1", seen); end
        wr0 = wr_cnt;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, mem_rd_req, mem_wr_en, busy} !== 4'b0000) begin
            n_err++; $display("FAIL rm_strobes: got %b want 0000", {out_valid, mem_rd_req, mem_wr_en, busy}); end
        n_cmp++; if ({out_idx, out_sum, out_spike, mem_wr_data, mem_rd_idx} !== 31'd0) begin
            n_err++; $display("FAIL rm_fields: got %0h want 0", {out_idx, out_sum, out_spike, mem_wr_data, mem_rd_idx}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (wr_cnt !== wr0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rm_dropped: got wr=%0d v=%0b busy=%0b want %0d/0/0", wr_cnt, out_valid, busy, wr0); end
        psum_idx = 5'd15; psum_lane = 2'd0;
        #1;
        n_cmp++; if (psum_ready !== 1'b1) begin n_err++; $display("FAIL rm_sb_cleared: got %0b want 1", psum_ready); end
        send_psum(5'd5, 2'd2, 9'd3, w);
        send_psum(5'd5, 2'd1, 9'd3, w);
        send_psum(5'd5, 2'd0, 9'd3, w);
        collect(idx, sum, spk, wen, widx, wdata, cyc);
        n_cmp++; if (idx !== 5'd5 || sum !== 10'd10 || spk !== 1'b0 || wen !== 1'b1 || wdata !== 10'd10) begin
            n_err++; $display("FAIL rm_fresh: got idx=%0d sum=%0d spk=%0b wen=%0b wd=%0d want 5/10/0/1/10", idx, sum, spk, wen, wdata); end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        mem_hold   = 1'b0;
        psum_valid = 1'b0;
        psum_lane  = 2'd0;
        psum_idx   = 5'd0;
        psum_data  = 9'd0;
        out_ready  = 1'b0;
        for (int i = 0; i < 32; i++) pot_mem[i] = 10'd0;
        repeat (3) @(posedge clk);
        test_reset();
        test_spike_latency();
        test_arith();
        test_duplicate();
        test_queue_full();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
